// File: rtl/unary_stream_gen.sv
// rtl/unary_stream_gen.sv - binary value to 2^BITWIDTH-bit unary bitstream (BITREV_EN selects bit-reversed coding)
module unary_stream_gen #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iValid,
    input  logic [BITWIDTH-1:0] iData,
    output logic                oReady,
    output logic                oBit,
    output logic                oBitValid,
    output logic                oDone
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]          state;
    logic [BITWIDTH-1:0] value;
    logic [BITWIDTH-1:0] cnt;
    logic                streamBit;
    logic                lastBit;

`ifdef BITREV_EN
    logic [BITWIDTH-1:0] cntRev;

    // Bit-reversed index spreads the ones evenly while keeping the exact count.
    always_comb begin
        cntRev = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            cntRev[i] = cnt[BITWIDTH-1-i];
        end
        streamBit = (value > cntRev);
    end
`else
    always_comb begin
        streamBit = (cnt < value);
    end
`endif

    // Termination on the all-ones count lets cnt wrap naturally without a carry bit.
    assign lastBit = &cnt;
    assign oReady  = (state == IDLE);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state     <= IDLE;
            value     <= '0;
            cnt       <= '0;
            oBit      <= 1'b0;
            oBitValid <= 1'b0;
            oDone     <= 1'b0;
        end else if (iClr) begin
            state     <= IDLE;
            cnt       <= '0;
            oBit      <= 1'b0;
            oBitValid <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oBit      <= 1'b0;
                    oBitValid <= 1'b0;
                    oDone     <= 1'b0;
                    if (iValid) begin
                        value <= iData;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                default: begin
                    if (iEn) begin
                        oBit      <= streamBit;
                        oBitValid <= 1'b1;
                        oDone     <= lastBit;
                        cnt       <= cnt + 1'b1;
                        if (lastBit) begin
                            state <= IDLE;
                        end
                    end else begin
                        oBit      <= 1'b0;
                        oBitValid <= 1'b0;
                        oDone     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
